ps2_letter_decoder: RTL

Upstream input stage of the typing game. Receives raw PS/2 keyboard frames (scan code set 2) on `ps2_clk`/`ps2_data`, validates them, and tracks make, break and extended prefixes. For every released letter key it delivers a 5-bit letter code on `kstrk` with a one-cycle strobe on `kr`, which is the interface the word checker consumes. Non-letter keys, extended keys and corrupted frames produce no strobe.

---
 rtl/typing_pkg.sv | 52 +++++
 rtl/ps2_frame_rx.sv | 150 +++++++++++++++
 rtl/ps2_letter_decoder.sv | 84 ++++++++
 3 files changed

// File: rtl/typing_pkg.sv
// Shared constants and the scan-code-set-2 letter lookup for the typing game input stage.
package typing_pkg;

  localparam int LETTER_W = 5;

  localparam logic [7:0] BRK_BYTE = 8'hF0;
  localparam logic [7:0] EXT_BYTE = 8'hE0;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  // Map a set-2 make code to A=1 .. Z=26; anything else maps to 0.
  function automatic logic [LETTER_W-1:0] scan_to_letter(input logic [7:0] code);
    logic [LETTER_W-1:0] l;
    l = '0;
    case (code)
      8'h1C: l = 5'd1;
      8'h32: l = 5'd2;
      8'h21: l = 5'd3;
      8'h23: l = 5'd4;
      8'h24: l = 5'd5;
      8'h2B: l = 5'd6;
      8'h34: l = 5'd7;
      8'h33: l = 5'd8;
      8'h43: l = 5'd9;
      8'h3B: l = 5'd10;
      8'h42: l = 5'd11;
      8'h4B: l = 5'd12;
      8'h3A: l = 5'd13;
      8'h31: l = 5'd14;
      8'h44: l = 5'd15;
      8'h4D: l = 5'd16;
      8'h15: l = 5'd17;
      8'h2D: l = 5'd18;
      8'h1B: l = 5'd19;
      8'h2C: l = 5'd20;
      8'h3C: l = 5'd21;
      8'h2A: l = 5'd22;
      8'h1D: l = 5'd23;
      8'h22: l = 5'd24;
      8'h35: l = 5'd25;
      8'h1A: l = 5'd26;
      default: l = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizers, ps2_clk glitch filter, 11-bit frame FSM and idle timeout.
// byte_vld_o is a one-cycle valid with no ready: the consumer must take byte_o in the cycle it is high.
module ps2_frame_rx
  import typing_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o,
  output logic [1:0] state_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_q, filt_d, filt_prev_q;
  logic          clk_s, data_s, fall;

  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    byte_q, byte_d;
  logic          vld_q, vld_d, err_q, err_d;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall   = filt_prev_q & ~filt_q;

  // Glitch filter: flip the filtered level after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_cnt_d = '0;
    filt_d     = filt_q;
    if (clk_s != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s;
      else filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  // Input conditioning registers; the bus idles high so everything resets to 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_cnt_q  <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_cnt_q  <= filt_cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
    end
  end

  // Frame FSM next state; a falling edge always beats the timeout in the same cycle.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_d      = to_q;
    byte_d    = byte_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      RX_IDLE: begin
        to_d      = '0;
        bit_cnt_d = '0;
        if (fall && !data_s) state_d = RX_DATA;
      end
      RX_DATA: begin
        if (fall) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fall) begin
          par_d   = data_s;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          if ((^{shift_q, par_q}) && data_s) begin
            vld_d  = 1'b1;
            byte_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
    if (state_q != RX_IDLE) begin
      if (fall) begin
        to_d = '0;
      end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d   = RX_IDLE;
        bit_cnt_d = '0;
        to_d      = '0;
        err_d     = 1'b1;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_q      <= '0;
      byte_q    <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_q      <= to_d;
      byte_q    <= byte_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

  assign byte_o      = byte_q;
  assign byte_vld_o  = vld_q;
  assign frame_err_o = err_q;
  assign state_o     = state_q;

endmodule

// File: rtl/ps2_letter_decoder.sv
// Top: tracks break/extended prefixes on received bytes and strobes the code of released letters.
module ps2_letter_decoder
  import typing_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [LETTER_W-1:0] kstrk,
  output logic                kr,
  output logic                frame_err,
  output logic [1:0]          dbg_rx_state
);

  logic [7:0]          rx_byte;
  logic                rx_vld, rx_err;
  logic [LETTER_W-1:0] letter;
  logic                brk_q, brk_d, ext_q, ext_d, kr_q, kr_d;
  logic [LETTER_W-1:0] kstrk_q, kstrk_d;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk_i      (clk),
    .rst_ni     (reset),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .byte_o     (rx_byte),
    .byte_vld_o (rx_vld),
    .frame_err_o(rx_err),
    .state_o    (dbg_rx_state)
  );

  assign letter = scan_to_letter(rx_byte);

  // Prefix tracking: E0/F0 set flags, any other byte closes the sequence; errors drop the flags.
  always_comb begin
    brk_d   = brk_q;
    ext_d   = ext_q;
    kstrk_d = kstrk_q;
    kr_d    = 1'b0;
    if (rx_err) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (rx_vld) begin
      if (rx_byte == EXT_BYTE) begin
        ext_d = 1'b1;
      end else if (rx_byte == BRK_BYTE) begin
        brk_d = 1'b1;
      end else begin
        if (brk_q && !ext_q && (letter != '0)) begin
          kstrk_d = letter;
          kr_d    = 1'b1;
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  // Flag and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      kstrk_q <= '0;
      kr_q    <= 1'b0;
    end else begin
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      kstrk_q <= kstrk_d;
      kr_q    <= kr_d;
    end
  end

  assign kstrk     = kstrk_q;
  assign kr        = kr_q;
  assign frame_err = rx_err;

endmodule
